matrix_dsp_sequencer: RTL

//  Microcode fetch/issue sequencer for the Matrix DSP. Drives address/enable into the

---
 rtl/matrix_dsp_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/matrix_dsp_sequencer.sv
// Matrix DSP microcode sequencer: fetches from a registered ROM, issues one
// instruction per cycle, handles datapath stall, one loop level and END.
module matrix_dsp_sequencer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] romAddr,
    output logic                  romEnable,
    input  logic [3:0]            romInputAAddress,
    input  logic                  romInputASelect,
    input  logic [3:0]            romInputBAddress,
    input  logic [1:0]            romInputBSelect,
    input  logic [2:0]            romOperation,
    input  logic [1:0]            romOutputAddress,
    output logic                  issueValid,
    output logic [3:0]            issueInputAAddress,
    output logic                  issueInputASelect,
    output logic [3:0]            issueInputBAddress,
    output logic [1:0]            issueInputBSelect,
    output logic [2:0]            issueOperation,
    output logic [1:0]            issueOutputAddress,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_END  = 3'b111;
    localparam logic [2:0] OP_LOOP = 3'b110;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] pc, next_pc, pc_inc, loop_target;
    logic                  loop_active, next_loop_active;
    logic [3:0]            loop_count, next_loop_count, remaining;

    assign pc_inc      = pc + ADDR_WIDTH'(1);
    assign loop_target = ADDR_WIDTH'({romInputBAddress, romInputBSelect,
                                      romOutputAddress});
    assign remaining   = loop_active ? loop_count : romInputAAddress;

    // Decoded fields go straight through; issueValid qualifies them.
    assign issueInputAAddress = romInputAAddress;
    assign issueInputASelect  = romInputASelect;
    assign issueInputBAddress = romInputBAddress;
    assign issueInputBSelect  = romInputBSelect;
    assign issueOperation     = romOperation;
    assign issueOutputAddress = romOutputAddress;

    // State, program counter and loop counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            loop_active <= 1'b0;
            loop_count  <= '0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            loop_active <= next_loop_active;
            loop_count  <= next_loop_count;
        end
    end

    // Next-state, fetch address and issue control.
    always_comb begin
        next_state       = state;
        next_pc          = pc;
        next_loop_active = loop_active;
        next_loop_count  = loop_count;
        romAddr          = pc;
        romEnable        = 1'b0;
        issueValid       = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state)
            IDLE: begin
                romAddr   = startAddr;
                romEnable = start;
                if (start) begin
                    next_pc    = startAddr;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (romOperation == OP_END) begin
                    next_state = FIN;
                end else if (romOperation == OP_LOOP) begin
                    romEnable = 1'b1;
                    if (remaining != 4'd0) begin
                        next_loop_active = 1'b1;
                        next_loop_count  = remaining - 4'd1;
                        romAddr          = loop_target;
                        next_pc          = loop_target;
                    end else begin
                        next_loop_active = 1'b0;
                        romAddr          = pc_inc;
                        next_pc          = pc_inc;
                    end
                end else begin
                    issueValid = 1'b1;
                    if (!stall) begin
                        romAddr   = pc_inc;
                        romEnable = 1'b1;
                        next_pc   = pc_inc;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
